core_run_controller: RTL

Sequences the 64-bit single-cycle RISC-V core from a single free-running clock. Issues a divided clock-enable pulse train to the core and holds core reset for a fixed count. Accepts run/halt/step/reset commands from the debug/testbench side over a valid/ready handshake. Sits between the clock source and the core; the core's state advances only on cycles where core_clk_en is high.

---
 rtl/core_ctrl_pkg.sv | 26 ++
 rtl/core_run_controller_clk_en_divider.sv | 29 ++
 rtl/core_run_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared encodings for the core run controller: FSM states, debug command
// opcodes and the reason the core was last stopped.
package core_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_HALT       = 2'd1,
        ST_RUN        = 2'd2,
        ST_STEP       = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_RUN   = 2'd0,
        OP_HALT  = 2'd1,
        OP_STEP  = 2'd2,
        OP_RESET = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_CMD       = 2'd1,
        CAUSE_HALT_REQ  = 2'd2,
        CAUSE_STEP_DONE = 2'd3
    } halt_cause_e;

endpackage

// File: rtl/core_run_controller_clk_en_divider.sv
// Clock-enable divider: asserts tick once every cfg_div+1 active cycles,
// restarting its count on the edge that (re)enters an active state.
module clk_en_divider #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             restart,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;

    // >= rather than == so a lowered cfg_div fires on the very next cycle
    assign tick = active && (div_cnt >= cfg_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (restart) begin
            div_cnt <= '0;
        end else if (active) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/core_run_controller.sv
// Run controller for the single-cycle core: reset hold, divided clock enable,
// and run/halt/step/reset command sequencing over a valid/ready handshake.
module core_run_controller
    import core_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned STEP_W   = 16,
    parameter int unsigned RST_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic              halt_req,
    output logic              core_clk_en,
    output logic              core_rst_n,
    output logic [1:0]        state_o,
    output logic [1:0]        halt_cause,
    output logic              step_done,
    output logic              cmd_err,
    output logic [63:0]       en_count
);

    localparam int unsigned       HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    state_e            state, state_nxt;
    halt_cause_e       cause_q, cause_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic [STEP_W-1:0] step_cnt, step_nxt;
    logic [63:0]       count_nxt;
    logic              clk_en_nxt, rst_n_nxt, done_nxt, err_nxt;
    logic              accept, running, tick, restart;
    cmd_op_e           op;

    assign cmd_ready  = (state != ST_RESET_HOLD);
    assign accept     = cmd_valid && cmd_ready;
    assign op         = cmd_op_e'(cmd_op);
    assign running    = (state == ST_RUN) || (state == ST_STEP);
    assign restart    = !running && ((state_nxt == ST_RUN) || (state_nxt == ST_STEP));
    assign state_o    = state;
    assign halt_cause = cause_q;

    clk_en_divider #(.DIV_W(DIV_W)) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (running),
        .restart (restart),
        .cfg_div (cfg_div),
        .tick    (tick)
    );

    always_comb begin
        state_nxt  = state;
        cause_nxt  = cause_q;
        hold_nxt   = hold_cnt;
        step_nxt   = step_cnt;
        count_nxt  = en_count;
        rst_n_nxt  = core_rst_n;
        clk_en_nxt = 1'b0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;

        if (state == ST_RESET_HOLD) begin
            if (hold_cnt == HOLD_LAST) begin
                state_nxt = ST_HALT;
                rst_n_nxt = 1'b1;
                hold_nxt  = '0;
            end else begin
                hold_nxt = hold_cnt + 1'b1;
            end
        end else if (accept && op == OP_RESET) begin
            state_nxt = ST_RESET_HOLD;
            rst_n_nxt = 1'b0;
            count_nxt = '0;
            hold_nxt  = '0;
            cause_nxt = CAUSE_NONE;
        end else if (state == ST_HALT) begin
            if (accept && op == OP_RUN) begin
                state_nxt = ST_RUN;
            end else if (accept && op == OP_STEP) begin
                if (cmd_arg == '0) begin
                    done_nxt = 1'b1;
                end else begin
                    state_nxt = ST_STEP;
                    step_nxt  = cmd_arg;
                end
            end
        end else if (halt_req) begin
            // halt_req outranks any non-reset command, which is then silently dropped
            state_nxt = ST_HALT;
            cause_nxt = CAUSE_HALT_REQ;
        end else if (accept && op == OP_HALT) begin
            state_nxt = ST_HALT;
            cause_nxt = CAUSE_CMD;
        end else begin
            clk_en_nxt = tick;
            if (accept && ((state == ST_RUN && op == OP_STEP) ||
                           (state == ST_STEP && op == OP_RUN))) begin
                err_nxt = 1'b1;
            end
            if (state == ST_STEP && tick) begin
                step_nxt = step_cnt - 1'b1;
                if (step_cnt == STEP_W'(1)) begin
                    state_nxt = ST_HALT;
                    done_nxt  = 1'b1;
                    cause_nxt = CAUSE_STEP_DONE;
                end
            end
        end

        if (clk_en_nxt) begin
            count_nxt = en_count + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RESET_HOLD;
            cause_q     <= CAUSE_NONE;
            hold_cnt    <= '0;
            step_cnt    <= '0;
            en_count    <= '0;
            core_rst_n  <= 1'b0;
            core_clk_en <= 1'b0;
            step_done   <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            cause_q     <= cause_nxt;
            hold_cnt    <= hold_nxt;
            step_cnt    <= step_nxt;
            en_count    <= count_nxt;
            core_rst_n  <= rst_n_nxt;
            core_clk_en <= clk_en_nxt;
            step_done   <= done_nxt;
            cmd_err     <= err_nxt;
        end
    end

endmodule
